// File: rtl/hls_deadlock_monitor_n.sv
// -----------------------------------------------------------------------------
// hls_deadlock_monitor_n
//
// Watches the stall indications of an HLS-generated dataflow region and
// produces a registered deadlock verdict. A "raw" block condition is seen when
// any AXIS channel reports blocked, or when every sub-instance is either
// blocked or idle with at least one of them blocked. The raw condition has to
// persist for THRESHOLD consecutive cycles before block is raised. The sources
// active on that cycle are latched into block_src.
//
// Parameters
//   NUM_AXIS  : number of AXIS block-sense inputs (1..64)
//   NUM_INST  : number of sub-instance idle/block pairs (1..32)
//   THRESHOLD : consecutive raw cycles needed before block (1..2^CNT_W-1)
//   CNT_W     : width of stall_cycles
//   STICKY    : 1 = block holds until clear/reset, 0 = block drops with raw
//
// Ports
//   clock           : rising-edge clock
//   reset           : asynchronous active-low reset
//   clear           : synchronous monitor clear, active high, wins over all
//   axis_block_sigs : per-AXIS-channel blocked indication
//   inst_idle_sigs  : per-sub-instance idle indication
//   inst_block_sigs : per-sub-instance blocked indication
//   block           : registered deadlock verdict
//   block_pending   : raw seen, threshold not reached yet (FSM in COUNT)
//   block_src       : {inst_block_sigs, axis_block_sigs} captured on block entry
//   stall_cycles    : saturating count of consecutive raw cycles
// -----------------------------------------------------------------------------
module hls_deadlock_monitor_n #(
  parameter int NUM_AXIS  = 3,
  parameter int NUM_INST  = 1,
  parameter int THRESHOLD = 16,
  parameter int CNT_W     = 8,
  parameter int STICKY    = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear,
  input  logic [NUM_AXIS-1:0]          axis_block_sigs,
  input  logic [NUM_INST-1:0]          inst_idle_sigs,
  input  logic [NUM_INST-1:0]          inst_block_sigs,
  output logic                         block,
  output logic                         block_pending,
  output logic [NUM_AXIS+NUM_INST-1:0] block_src,
  output logic [CNT_W-1:0]             stall_cycles
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    BLOCKED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESHOLD);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                       state;
  logic                         axis_any;
  logic                         inst_all;
  logic                         raw;
  logic [CNT_W-1:0]             stall_inc;
  logic [NUM_AXIS+NUM_INST-1:0] src_now;

  // Raw deadlock condition. The instance term needs at least one blocked
  // instance so that a fully idle region is not mistaken for a deadlock.
  always_comb begin
    axis_any  = |axis_block_sigs;
    inst_all  = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs);
    raw       = axis_any | inst_all;
    src_now   = {inst_block_sigs, axis_block_sigs};
    stall_inc = (stall_cycles == CNT_MAX) ? stall_cycles : stall_cycles + CNT_ONE;
  end

  // Monitor FSM. Every output is a flop written here, so nothing combinational
  // reaches the ports. clear is checked ahead of the state case so it beats
  // any transition on the same edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      block         <= 1'b0;
      block_pending <= 1'b0;
      block_src     <= '0;
      stall_cycles  <= '0;
    end else if (clear) begin
      state         <= IDLE;
      block         <= 1'b0;
      block_pending <= 1'b0;
      block_src     <= '0;
      stall_cycles  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (raw) begin
            stall_cycles <= CNT_ONE;
            if (THRESHOLD == 1) begin
              state         <= BLOCKED;
              block         <= 1'b1;
              block_pending <= 1'b0;
              block_src     <= src_now;
            end else begin
              state         <= COUNT;
              block_pending <= 1'b1;
            end
          end
        end

        COUNT: begin
          if (raw) begin
            stall_cycles <= stall_inc;
            if (stall_inc >= THRESH_C) begin
              state         <= BLOCKED;
              block         <= 1'b1;
              block_pending <= 1'b0;
              block_src     <= src_now;
            end
          end else begin
            state         <= IDLE;
            block_pending <= 1'b0;
            stall_cycles  <= '0;
          end
        end

        BLOCKED: begin
          // block_src is deliberately left alone so it keeps the first capture.
          // When sticky and raw goes away the verdict stays, but the
          // consecutive-cycle count restarts since the run has been broken.
          if (raw) begin
            stall_cycles <= stall_inc;
          end else if (STICKY == 0) begin
            state        <= IDLE;
            block        <= 1'b0;
            stall_cycles <= '0;
          end else begin
            stall_cycles <= '0;
          end
        end

        default: begin
          state         <= IDLE;
          block         <= 1'b0;
          block_pending <= 1'b0;
          stall_cycles  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hls_deadlock_monitor_n.sv
// -----------------------------------------------------------------------------
// tb_hls_deadlock_monitor_n
//
// Three monitor instances share clock/reset/clear:
//   dut_a : defaults (3 AXIS, 1 instance, threshold 16, sticky)
//   dut_b : 2 sub-instances, otherwise defaults
//   dut_c : non-sticky, threshold 1, 2-bit counter
// Stimulus pushes hand-computed expectations into a queue; a separate monitor
// pops them on the falling edge (or immediately on check_now for the
// asynchronous reset checks) and compares against the selected instance.
// -----------------------------------------------------------------------------
module tb_hls_deadlock_monitor_n;

  logic clock = 1'b0;
  logic reset;
  logic clear;

  logic [2:0] axis_a, axis_b, axis_c;
  logic [0:0] idle_a, blk_a, idle_c, blk_c;
  logic [1:0] idle_b, blk_b;

  logic       block_a, pend_a, block_b, pend_b, block_c, pend_c;
  logic [3:0] src_a, src_c;
  logic [4:0] src_b;
  logic [7:0] stall_a, stall_b;
  logic [1:0] stall_c;

  typedef struct {
    int         dut;
    string      name;
    logic       blk;
    logic       pend;
    logic [7:0] src;
    logic [7:0] stall;
    bit         chk_stall;
  } exp_t;

  exp_t exp_q[$];
  int   total_checks = 0;
  int   bad_checks   = 0;
  event check_now;

  always #5 clock = ~clock;

  hls_deadlock_monitor_n dut_a (
    .clock(clock), .reset(reset), .clear(clear),
    .axis_block_sigs(axis_a), .inst_idle_sigs(idle_a), .inst_block_sigs(blk_a),
    .block(block_a), .block_pending(pend_a), .block_src(src_a), .stall_cycles(stall_a)
  );

  hls_deadlock_monitor_n #(.NUM_INST(2)) dut_b (
    .clock(clock), .reset(reset), .clear(clear),
    .axis_block_sigs(axis_b), .inst_idle_sigs(idle_b), .inst_block_sigs(blk_b),
    .block(block_b), .block_pending(pend_b), .block_src(src_b), .stall_cycles(stall_b)
  );

  hls_deadlock_monitor_n #(.STICKY(0), .THRESHOLD(1), .CNT_W(2)) dut_c (
    .clock(clock), .reset(reset), .clear(clear),
    .axis_block_sigs(axis_c), .inst_idle_sigs(idle_c), .inst_block_sigs(blk_c),
    .block(block_c), .block_pending(pend_c), .block_src(src_c), .stall_cycles(stall_c)
  );

  function automatic void push_expected(input int dut, input string name,
                                        input logic blk, input logic pend,
                                        input logic [7:0] src, input logic [7:0] stall,
                                        input bit chk_stall);
    exp_t e;
    e.dut       = dut;
    e.name      = name;
    e.blk       = blk;
    e.pend      = pend;
    e.src       = src;
    e.stall     = stall;
    e.chk_stall = chk_stall;
    exp_q.push_back(e);
  endfunction

  // Compares one expectation against the instance it names.
  task automatic checkOutput(input exp_t e);
    logic       a_blk, a_pend;
    logic [7:0] a_src, a_stall;
    bit         ok;
    case (e.dut)
      0:       begin a_blk = block_a; a_pend = pend_a; a_src = {4'b0, src_a}; a_stall = stall_a; end
      1:       begin a_blk = block_b; a_pend = pend_b; a_src = {3'b0, src_b}; a_stall = stall_b; end
      default: begin a_blk = block_c; a_pend = pend_c; a_src = {4'b0, src_c}; a_stall = {6'b0, stall_c}; end
    endcase
    ok = (a_blk === e.blk) && (a_pend === e.pend) && (a_src === e.src) &&
         (!e.chk_stall || (a_stall === e.stall));
    total_checks++;
    if (!ok) begin
      bad_checks++;
      $display("[TB] FAIL %s: got block=%0b pending=%0b src=%h stall=%0d, want block=%0b pending=%0b src=%h stall=%0d%s",
               e.name, a_blk, a_pend, a_src, a_stall, e.blk, e.pend, e.src, e.stall,
               e.chk_stall ? "" : " (stall not checked)");
    end
  endtask

  // Monitor: drains the expectation queue away from the rising edge.
  initial begin
    forever begin
      @(negedge clock or check_now);
      while (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput(e);
      end
    end
  end

  // One rising edge, then settle 1ns past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int dut, input logic [2:0] axis,
                               input logic [1:0] idle, input logic [1:0] blk);
    case (dut)
      0:       begin axis_a = axis; idle_a = idle[0:0]; blk_a = blk[0:0]; end
      1:       begin axis_b = axis; idle_b = idle;      blk_b = blk;      end
      default: begin axis_c = axis; idle_c = idle[0:0]; blk_c = blk[0:0]; end
    endcase
  endtask

  initial begin
    reset  = 1'b0;
    clear  = 1'b0;
    axis_a = '0; idle_a = '0; blk_a = '0;
    axis_b = '0; idle_b = '0; blk_b = '0;
    axis_c = '0; idle_c = '0; blk_c = '0;

    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    step();
    push_expected(0, "reset_a", 0, 0, 8'h00, 8'd0, 1);
    push_expected(1, "reset_b", 0, 0, 8'h00, 8'd0, 1);
    push_expected(2, "reset_c", 0, 0, 8'h00, 8'd0, 1);

    // Threshold reached after 16 consecutive raw cycles.
    applyStimulus(0, 3'b010, 2'b00, 2'b00);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k < 16) push_expected(0, "thr_count", 0, 1, 8'h00, 8'(k), 1);
      else        push_expected(0, "thr_block", 1, 0, 8'h02, 8'd16, 1);
    end

    // Sticky verdict survives raw dropping.
    applyStimulus(0, 3'b000, 2'b00, 2'b00);
    for (int k = 0; k < 20; k++) begin
      step();
      push_expected(0, "sticky_hold", 1, 0, 8'h02, 8'd0, 0);
    end

    clear = 1'b1;
    step();
    clear = 1'b0;
    push_expected(0, "clear_all", 0, 0, 8'h00, 8'd0, 1);

    // Clear beats raw on the same edge, then evaluation resumes.
    applyStimulus(0, 3'b001, 2'b00, 2'b00);
    for (int k = 1; k <= 3; k++) begin
      step();
      push_expected(0, "prio_count", 0, 1, 8'h00, 8'(k), 1);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    push_expected(0, "clear_prio", 0, 0, 8'h00, 8'd0, 1);
    step();
    push_expected(0, "clear_resume", 0, 1, 8'h00, 8'd1, 1);
    applyStimulus(0, 3'b000, 2'b00, 2'b00);
    step();
    push_expected(0, "resume_drop", 0, 0, 8'h00, 8'd0, 1);

    // Raw for 10 cycles only: no verdict, counter returns to 0.
    applyStimulus(0, 3'b001, 2'b00, 2'b00);
    for (int k = 1; k <= 10; k++) begin
      step();
      push_expected(0, "short_count", 0, 1, 8'h00, 8'(k), 1);
    end
    applyStimulus(0, 3'b000, 2'b00, 2'b00);
    step();
    push_expected(0, "short_drop", 0, 0, 8'h00, 8'd0, 1);
    step();
    push_expected(0, "short_idle", 0, 0, 8'h00, 8'd0, 1);

    // Instance deadlock: inst0 idle, inst1 blocked.
    applyStimulus(1, 3'b000, 2'b01, 2'b10);
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k < 16) push_expected(1, "inst_count", 0, 1, 8'h00, 8'(k), 1);
      else        push_expected(1, "inst_block", 1, 0, 8'h10, 8'd16, 1);
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    push_expected(1, "inst_clear", 0, 0, 8'h00, 8'd0, 1);

    // inst0 busy (neither idle nor blocked): no raw.
    applyStimulus(1, 3'b000, 2'b00, 2'b10);
    for (int k = 0; k < 16; k++) begin
      step();
      push_expected(1, "inst_busy", 0, 0, 8'h00, 8'd0, 1);
    end
    // Everything idle, nothing blocked: no raw.
    applyStimulus(1, 3'b000, 2'b11, 2'b00);
    step();
    push_expected(1, "inst_all_idle", 0, 0, 8'h00, 8'd0, 1);
    // Everything blocked: raw.
    applyStimulus(1, 3'b000, 2'b00, 2'b11);
    step();
    push_expected(1, "inst_all_blk", 0, 1, 8'h00, 8'd1, 1);
    applyStimulus(1, 3'b000, 2'b00, 2'b00);
    step();
    push_expected(1, "inst_release", 0, 0, 8'h00, 8'd0, 1);

    // Non-sticky, threshold 1, 2-bit saturating counter.
    applyStimulus(2, 3'b100, 2'b00, 2'b00);
    for (int k = 1; k <= 6; k++) begin
      step();
      push_expected(2, "ns_block", 1, 0, 8'h04, (k < 3) ? 8'(k) : 8'd3, 1);
    end
    applyStimulus(2, 3'b000, 2'b00, 2'b00);
    step();
    push_expected(2, "ns_fall", 0, 0, 8'h04, 8'd0, 1);
    step();
    push_expected(2, "ns_idle", 0, 0, 8'h04, 8'd0, 1);

    // Asynchronous reset mid-COUNT.
    applyStimulus(0, 3'b010, 2'b00, 2'b00);
    for (int k = 1; k <= 5; k++) begin
      step();
      push_expected(0, "pre_reset_cnt", 0, 1, 8'h00, 8'(k), 1);
    end
    #5 reset = 1'b0;
    #1 push_expected(0, "async_rst_count", 0, 0, 8'h00, 8'd0, 1);
    ->check_now;
    #1 applyStimulus(0, 3'b000, 2'b00, 2'b00);
    reset = 1'b1;
    step();
    push_expected(0, "post_rst_count", 0, 0, 8'h00, 8'd0, 1);

    // Asynchronous reset in BLOCKED.
    applyStimulus(0, 3'b010, 2'b00, 2'b00);
    repeat (16) step();
    push_expected(0, "pre_reset_blk", 1, 0, 8'h02, 8'd16, 1);
    #5 reset = 1'b0;
    #1 push_expected(0, "async_rst_blk", 0, 0, 8'h00, 8'd0, 1);
    ->check_now;
    #1 applyStimulus(0, 3'b000, 2'b00, 2'b00);
    reset = 1'b1;
    step();
    push_expected(0, "post_rst_blk", 0, 0, 8'h00, 8'd0, 1);

    step();
    @(negedge clock);
    #1;
    if (exp_q.size() != 0) begin
      bad_checks++;
      $display("[TB] FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
